// File: rtl/rpc_echo_pkg.sv
// rpc_echo_pkg: flow-ID sizing shared by the echo scheduler, controller and datapath
package rpc_echo_pkg;
    localparam int MAX_FLOWS = 8;
    localparam int FLOWID_W  = $clog2(MAX_FLOWS);
    typedef logic [FLOWID_W-1:0] flowid_t;
endpackage

// File: rtl/rpc_echo_flowid_fifo_mem.sv
// rpc_echo_flowid_fifo_mem: flow-ID storage, one write port and one asynchronous read port
module rpc_echo_flowid_fifo_mem #(
    parameter int DEPTH = rpc_echo_pkg::MAX_FLOWS,
    parameter int W     = rpc_echo_pkg::FLOWID_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/rpc_echo_flow_sched.sv
// rpc_echo_flow_sched: circular FIFO of active flow IDs served to the echo controller
// tracked/resident bitmaps keep each ID at most once across the FIFO and the controller
module rpc_echo_flow_sched #(
    parameter int MAX_FLOWS = rpc_echo_pkg::MAX_FLOWS,
    parameter int FLOWID_W  = $clog2(MAX_FLOWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                new_flow_val,
    input  logic [FLOWID_W-1:0] new_flow_flowid,
    output logic                new_flow_rdy,
    input  logic                close_flow_val,
    input  logic [FLOWID_W-1:0] close_flow_flowid,
    input  logic                ctrl_requeue_flow_val,
    input  logic [FLOWID_W-1:0] ctrl_requeue_flowid,
    output logic                flow_fifo_ctrl_enqueue_rdy,
    output logic                flow_fifo_ctrl_flowid_val,
    output logic [FLOWID_W-1:0] flow_fifo_ctrl_flowid,
    input  logic                ctrl_flow_fifo_flowid_yumi,
    output logic [FLOWID_W:0]   sched_count
);
    localparam logic [FLOWID_W:0]    FULL = (FLOWID_W+1)'(MAX_FLOWS);
    localparam logic [MAX_FLOWS-1:0] ONE  = {{(MAX_FLOWS-1){1'b0}}, 1'b1};

    logic [FLOWID_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [FLOWID_W:0]    r_count;
    logic [MAX_FLOWS-1:0] r_tracked, r_resident;
    logic                 w_full, w_empty, w_rq_acc, w_rq_push, w_rq_drop;
    logic                 w_nf_push, w_push, w_head_trk, w_skip, w_pop;
    logic [FLOWID_W-1:0]  w_head, w_wdata;
    logic [MAX_FLOWS-1:0] w_close_mask, w_nf_mask, w_drop_mask, w_skip_mask;

    rpc_echo_flowid_fifo_mem #(.DEPTH(MAX_FLOWS), .W(FLOWID_W)) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    assign w_full    = r_count == FULL;
    assign w_empty   = r_count == '0;
    assign w_rq_acc  = ctrl_requeue_flow_val && !w_full;
    assign w_rq_push = w_rq_acc && r_tracked[ctrl_requeue_flowid];
    assign w_rq_drop = w_rq_acc && !r_tracked[ctrl_requeue_flowid];

    // a stale copy still draining blocks re-opening the same ID
    assign new_flow_rdy = (close_flow_val && close_flow_flowid == new_flow_flowid) ? 1'b0 :
                          r_tracked[new_flow_flowid]  ? 1'b1 :
                          r_resident[new_flow_flowid] ? 1'b0 :
                          !(ctrl_requeue_flow_val || w_full);
    assign w_nf_push = new_flow_val && new_flow_rdy && !r_tracked[new_flow_flowid];
    assign w_push    = w_rq_push || w_nf_push;
    assign w_wdata   = w_rq_push ? ctrl_requeue_flowid : new_flow_flowid;

    assign w_head_trk                 = r_tracked[w_head];
    assign flow_fifo_ctrl_flowid_val  = !w_empty && w_head_trk;
    assign flow_fifo_ctrl_flowid      = w_empty ? '0 : w_head;
    assign flow_fifo_ctrl_enqueue_rdy = !w_full;
    assign sched_count                = r_count;
    assign w_skip = !w_empty && !w_head_trk;
    assign w_pop  = w_skip || (flow_fifo_ctrl_flowid_val && ctrl_flow_fifo_flowid_yumi);

    assign w_close_mask = close_flow_val ? ONE << close_flow_flowid : '0;
    assign w_nf_mask    = w_nf_push ? ONE << new_flow_flowid : '0;
    assign w_drop_mask  = w_rq_drop ? ONE << ctrl_requeue_flowid : '0;
    assign w_skip_mask  = w_skip ? ONE << w_head : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tracked  <= '0;
            r_resident <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= r_count + (FLOWID_W+1)'(w_push) - (FLOWID_W+1)'(w_pop);
            r_tracked  <= (r_tracked & ~w_close_mask) | w_nf_mask;
            r_resident <= (r_resident & ~w_drop_mask & ~w_skip_mask) | w_nf_mask;
        end
    end
endmodule

// File: tb/tb_rpc_echo_flow_sched.sv
// tb_rpc_echo_flow_sched: scoreboard bench with a queue-based reference model of the scheduler
module tb_rpc_echo_flow_sched;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         new_flow_val = 1'b0, close_flow_val = 1'b0, ctrl_requeue_flow_val = 1'b0;
    logic         ctrl_flow_fifo_flowid_yumi = 1'b0;
    logic [W-1:0] new_flow_flowid = '0, close_flow_flowid = '0, ctrl_requeue_flowid = '0;
    logic         new_flow_rdy, flow_fifo_ctrl_enqueue_rdy, flow_fifo_ctrl_flowid_val;
    logic [W-1:0] flow_fifo_ctrl_flowid;
    logic [W:0]   sched_count;

    rpc_echo_flow_sched #(.MAX_FLOWS(N), .FLOWID_W(W)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .new_flow_val               (new_flow_val),
        .new_flow_flowid            (new_flow_flowid),
        .new_flow_rdy               (new_flow_rdy),
        .close_flow_val             (close_flow_val),
        .close_flow_flowid          (close_flow_flowid),
        .ctrl_requeue_flow_val      (ctrl_requeue_flow_val),
        .ctrl_requeue_flowid        (ctrl_requeue_flowid),
        .flow_fifo_ctrl_enqueue_rdy (flow_fifo_ctrl_enqueue_rdy),
        .flow_fifo_ctrl_flowid_val  (flow_fifo_ctrl_flowid_val),
        .flow_fifo_ctrl_flowid      (flow_fifo_ctrl_flowid),
        .ctrl_flow_fifo_flowid_yumi (ctrl_flow_fifo_flowid_yumi),
        .sched_count                (sched_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit enq;
        bit nfr;
        bit val;
        bit chk_id;
        int id;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // reference model: FIFO as a queue, open flows, flows held by the controller
    int q[$];
    bit trk[N];
    bit held[N];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic bit in_q(int x);
        foreach (q[i]) if (q[i] == x) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_nf_rdy(bit cv, int ci, int ni, bit rv);
        if (cv && ci == ni) return 1'b0;
        if (trk[ni]) return 1'b1;
        if (in_q(ni) || held[ni]) return 1'b0;
        return !(rv || q.size() == N);
    endfunction

    function automatic void model_clear();
        q.delete();
        foreach (trk[i]) begin
            trk[i] = 1'b0;
            held[i] = 1'b0;
        end
    endfunction

    task automatic cyc(input bit nv, input int ni, input bit cv, input int ci,
                       input bit rv, input int ri, input bit y);
        exp_t e;
        bit   full, nfr, val, yy;
        int   h;
        @(negedge clk);
        full = q.size() == N;
        nfr  = model_nf_rdy(cv, ci, ni, rv);
        h    = q.size() > 0 ? q[0] : 0;
        val  = q.size() > 0 && trk[h];
        yy   = y && val;
        new_flow_val               = nv;
        new_flow_flowid            = W'(ni);
        close_flow_val             = cv;
        close_flow_flowid          = W'(ci);
        ctrl_requeue_flow_val      = rv;
        ctrl_requeue_flowid        = W'(ri);
        ctrl_flow_fifo_flowid_yumi = yy;
        e = '{enq: !full, nfr: nfr, val: val, chk_id: val || q.size() == 0,
              id: val ? h : 0, cnt: q.size()};
        sb.push_back(e);
        if (q.size() > 0 && (!trk[h] || yy)) begin
            void'(q.pop_front());
            if (yy) held[h] = 1'b1;
        end
        if (rv && !full) begin
            held[ri] = 1'b0;
            if (trk[ri]) q.push_back(ri);
        end else if (nv && nfr && !trk[ni]) begin
            q.push_back(ni);
            trk[ni] = 1'b1;
        end
        if (cv) trk[ci] = 1'b0;
    endtask

    task automatic idle(input bit y);
        cyc(0, 0, 0, 0, 0, 0, y);
    endtask

    task automatic hard_reset();
        @(negedge clk);
        #3;
        new_flow_val = 1'b0;
        close_flow_val = 1'b0;
        ctrl_requeue_flow_val = 1'b0;
        ctrl_flow_fifo_flowid_yumi = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_enqueue_rdy", flow_fifo_ctrl_enqueue_rdy, 1);
        chk("rst_new_flow_rdy", new_flow_rdy, 1);
        chk("rst_flowid_val", flow_fifo_ctrl_flowid_val, 0);
        chk("rst_flowid", flow_fifo_ctrl_flowid, 0);
        chk("rst_sched_count", sched_count, 0);
        model_clear();
        @(negedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("enqueue_rdy", flow_fifo_ctrl_enqueue_rdy, e.enq);
                chk("new_flow_rdy", new_flow_rdy, e.nfr);
                chk("flowid_val", flow_fifo_ctrl_flowid_val, e.val);
                if (e.chk_id) chk("flowid", flow_fifo_ctrl_flowid, e.id);
                chk("sched_count", sched_count, e.cnt);
            end
        end
    end

    initial begin : stim
        int hl[$];
        int ri;
        model_clear();
        hard_reset();
        cyc(1, 3, 0, 0, 0, 0, 0);
        cyc(1, 5, 0, 0, 0, 0, 0);
        cyc(1, 3, 0, 0, 0, 0, 0);
        repeat (3) idle(1);
        cyc(1, 1, 0, 0, 0, 0, 0);
        idle(1);
        cyc(1, 2, 0, 0, 1, 1, 0);
        cyc(1, 2, 0, 0, 0, 0, 0);
        repeat (3) idle(1);
        cyc(1, 4, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 4, 0, 0, 0);
        repeat (2) idle(0);
        cyc(1, 4, 0, 0, 0, 0, 0);
        idle(1);
        cyc(1, 6, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 1, 6, 0, 0, 0);
        cyc(1, 6, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 6, 0);
        cyc(1, 6, 0, 0, 0, 0, 0);
        idle(0);
        hard_reset();
        for (int i = 0; i < N; i++) cyc(1, i, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        repeat (12) idle(1);
        hard_reset();
        repeat (3000) begin
            hl.delete();
            foreach (held[i]) if (held[i]) hl.push_back(i);
            ri = hl.size() > 0 ? hl[$urandom_range(hl.size() - 1)] : 0;
            cyc($urandom_range(1), $urandom_range(N - 1),
                $urandom_range(5) == 0, $urandom_range(N - 1),
                hl.size() > 0 && $urandom_range(1) == 1, ri,
                $urandom_range(2) != 0);
        end
        idle(0);
        hard_reset();
        for (int i = 0; i < 5; i++) cyc(1, i, 0, 0, 0, 0, 0);
        idle(0);
        hard_reset();
        idle(0);
        @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rpc_echo_flow_sched.md
# rpc_echo_flow_sched

Active-flow scheduler for the RPC echo application. It keeps a circular FIFO of flow IDs that are waiting for service and hands them one at a time to the echo app controller through a valid/yumi port. It takes re-enqueues of the same flows back from the controller, and new-flow and close notifications from the TCP connection side. Two bitmaps, tracked and resident, guarantee that each flow ID appears at most once across the FIFO and the controller. Closed flows are drained without stalling the controller.

## Interface
Parameters:
- MAX_FLOWS, 8: number of flow IDs and FIFO depth; must be a power of 2.
- FLOWID_W, $clog2(MAX_FLOWS): flow ID width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- new_flow_val  in  1  new connection notification.
- new_flow_flowid  in  FLOWID_W  ID of the new flow.
- new_flow_rdy  out  1  new-flow accept.
- close_flow_val  in  1  flow closed; always accepted, no rdy.
- close_flow_flowid  in  FLOWID_W  ID of the closed flow.
- ctrl_requeue_flow_val  in  1  controller re-enqueue request.
- ctrl_requeue_flowid  in  FLOWID_W  ID being re-enqueued.
- flow_fifo_ctrl_enqueue_rdy  out  1  re-enqueue accept.
- flow_fifo_ctrl_flowid_val  out  1  head flow available to the controller.
- flow_fifo_ctrl_flowid  out  FLOWID_W  head flow ID.
- ctrl_flow_fifo_flowid_yumi  in  1  controller takes the head; only legal while val=1.
- sched_count  out  FLOWID_W+1  current FIFO occupancy.

## Operation
State:
- wr_ptr and rd_ptr, FLOWID_W bits each, wrap naturally.
- count register, FLOWID_W+1 bits.
- tracked[MAX_FLOWS]: flow is open.
- resident[MAX_FLOWS]: the flow's ID is in the FIFO or held by the controller.

The FIFO has one write port. A requeue has priority over a new flow.

Requeue of flow X:
- flow_fifo_ctrl_enqueue_rdy = (count != MAX_FLOWS).
- On accept with tracked[X]=1: write X and increment count.
- On accept with tracked[X]=0: drop X, no write, clear resident[X].

New flow X: evaluate the following in order.
- close_flow_val with close ID = X in the same cycle: rdy=0.
- tracked[X]=1: rdy=1; the duplicate is dropped with no state change.
- resident[X]=1 and tracked[X]=0: rdy=0, because a stale copy is still draining.
- ctrl_requeue_flow_val=1 or count==MAX_FLOWS: rdy=0.
- Otherwise: rdy=1; on accept write X and set tracked[X] and resident[X].

Close of flow X:
- Clear tracked[X].
- Has no effect on resident or on the FIFO contents.

Dequeue, with head H = mem[rd_ptr] and count != 0:
- tracked[H]=1: flowid_val=1 and flowid=H. yumi pops the entry; resident[H] stays set.
- tracked[H]=0: flowid_val=0. The entry is popped internally the same cycle and resident[H] is cleared (skip).

Simultaneous events:
- Push and pop in the same cycle: count is unchanged.
- A close of H in the same cycle as yumi on H: the yumi completes. The flow is dropped later, at its requeue.
- Requeue drop and head skip of different IDs in the same cycle both clear their resident bits.
- A requeue drop and a skip of the same ID in the same cycle cannot occur while the invariant holds.

Invariant: with legal stimulus, count <= number of resident bits set <= MAX_FLOWS.

## Timing
- Reset values:
  - Pointers, count, tracked and resident are all 0.
  - flowid_val=0.
  - flowid=0 (memory is not reset; the output is masked while the FIFO is empty).
  - enqueue_rdy=1.
  - new_flow_rdy=1 when new_flow_val=0.
  - sched_count=0.
- Reset applied mid-operation clears all state immediately, regardless of the clock. In-flight controller flows are forgotten.
- Write-to-head latency is 1 cycle. An ID written in cycle N can be presented in cycle N+1; there is no same-cycle bypass.
- All rdy outputs and flowid_val are combinational from registers plus the current-cycle inputs named above. None depends on yumi.
- Full is judged from the registered count. A pop in the same cycle does not free a slot for a push.
- A skip consumes one cycle per stale entry.

## Structure
- Shared package rpc_echo_pkg holds MAX_FLOWS, FLOWID_W and the flowid_t typedef, shared with the echo controller and its datapath.
- One sub-module, rpc_echo_flowid_fifo_mem: a MAX_FLOWS x FLOWID_W register array with one write port and one asynchronous read port.
- Bitmaps, pointers and arbitration live in the top module. There is no explicit FSM; behaviour is derived from the bitmaps.

## Test plan
- Reset, then new flows 3, 5, 3: rdy=1 each time; only 3 and 5 enter; head sequence is 3 then 5; sched_count=2.
- Requeue 1 and new flow 2 in the same cycle: requeue accepted, new_flow_rdy=0. Flow 2 is accepted next cycle. Heads are 1 then 2.
- Flow 4 enqueued, then close 4 before dequeue: flowid_val stays 0; skip takes 1 cycle; resident[4]=0; a new flow 4 afterwards is accepted.
- Flow 6 dequeued by the controller, close 6, requeue 6: enqueue_rdy=1, no write, count unchanged. A new flow 6 is stalled (rdy=0) before the requeue and accepted after.
- Fill with 8 flows, then requeue: enqueue_rdy=0. Yumi on the head and requeue in the same cycle: still rdy=0. The requeue is accepted in the next cycle.
- Assert rst asynchronously mid-stream with count=5: outputs return to their reset values before the next clock edge, and sched_count=0.
